// File: rtl/lsq_store_joiner.sv
// Pairs store data and store addresses in arrival order and issues one registered write per pair,
// with in-flight write tracking. Define LSQ_STORE_JOINER_PERF_EN to add the stallCycles counter.
module lsq_store_joiner #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataIn_valid,
  output logic                  dataIn_ready,
  input  logic [ADDR_WIDTH-1:0] addrIn,
  input  logic                  addrIn_valid,
  output logic                  addrIn_ready,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memData,
  output logic                  memWrite_valid,
  input  logic                  memWrite_ready,
  input  logic                  memAck,
  output logic [7:0]            pending,
  output logic                  idle,
  output logic                  ackErr
`ifdef LSQ_STORE_JOINER_PERF_EN
  ,
  output logic [31:0]           stallCycles
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] d_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] d_mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] a_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] a_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d;
  logic [PTR_W-1:0]      a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic [CNT_W-1:0]      d_cnt_q, d_cnt_d, a_cnt_q, a_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]            pending_q, pending_d;
  logic                  ack_err_q, ack_err_d;

  logic       d_empty, a_empty, d_push, a_push, fire;
  logic       pairs_avail, room, load;
  logic [8:0] pending_sum, pending_next_excl;

  assign d_empty      = (d_cnt_q == '0);
  assign a_empty      = (a_cnt_q == '0);
  assign dataIn_ready = (d_cnt_q != CNT_W'(FIFO_DEPTH));
  assign addrIn_ready = (a_cnt_q != CNT_W'(FIFO_DEPTH));
  assign d_push       = dataIn_valid && dataIn_ready;
  assign a_push       = addrIn_valid && addrIn_ready;
  assign fire         = out_valid_q && memWrite_ready;

  // Projected occupancy after this cycle's issue/ack, clamped at zero; the throttle looks at this.
  assign pending_sum       = {1'b0, pending_q} + {8'd0, fire};
  assign pending_next_excl = (memAck && (pending_sum != '0)) ? pending_sum - 9'd1 : pending_sum;
  assign pairs_avail       = !d_empty && !a_empty && (!out_valid_q || fire);
  assign room              = (pending_next_excl < 9'(MAX_OUTSTANDING));
  assign load              = pairs_avail && room;

  always_comb begin
    d_mem_d  = d_mem_q;
    a_mem_d  = a_mem_q;
    d_wptr_d = d_wptr_q;
    a_wptr_d = a_wptr_q;
    d_rptr_d = d_rptr_q;
    a_rptr_d = a_rptr_q;
    if (d_push) begin
      d_mem_d[d_wptr_q] = dataIn;
      d_wptr_d          = d_wptr_q + PTR_W'(1);
    end
    if (a_push) begin
      a_mem_d[a_wptr_q] = addrIn;
      a_wptr_d          = a_wptr_q + PTR_W'(1);
    end
    if (load) begin
      d_rptr_d = d_rptr_q + PTR_W'(1);
      a_rptr_d = a_rptr_q + PTR_W'(1);
    end
    d_cnt_d = d_cnt_q + CNT_W'(d_push) - CNT_W'(load);
    a_cnt_d = a_cnt_q + CNT_W'(a_push) - CNT_W'(load);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_addr_d  = a_mem_q[a_rptr_q];
      out_data_d  = d_mem_q[d_rptr_q];
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
    pending_d = pending_next_excl[7:0];
    ack_err_d = ack_err_q || (memAck && (pending_sum == '0));
  end

  always_ff @(posedge clk) begin
    d_mem_q <= d_mem_d;
    a_mem_q <= a_mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_wptr_q    <= '0;
      d_rptr_q    <= '0;
      d_cnt_q     <= '0;
      a_wptr_q    <= '0;
      a_rptr_q    <= '0;
      a_cnt_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      pending_q   <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      d_wptr_q    <= d_wptr_d;
      d_rptr_q    <= d_rptr_d;
      d_cnt_q     <= d_cnt_d;
      a_wptr_q    <= a_wptr_d;
      a_rptr_q    <= a_rptr_d;
      a_cnt_q     <= a_cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      pending_q   <= pending_d;
      ack_err_q   <= ack_err_d;
    end
  end

`ifdef LSQ_STORE_JOINER_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_inc;

  // A stall is either back-pressure on a held request or a load held off only by the throttle.
  assign stall_inc = (out_valid_q && !memWrite_ready) || (pairs_avail && !room);

  always_comb begin
    stall_d = stall_q;
    if (stall_inc && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stallCycles = stall_q;
`endif

  assign memWrite_valid = out_valid_q;
  assign memAddr        = out_addr_q;
  assign memData        = out_data_q;
  assign pending        = pending_q;
  assign ackErr         = ack_err_q;
  assign idle           = d_empty && a_empty && !out_valid_q && (pending_q == '0);

endmodule

// File: tb/tb_lsq_store_joiner.sv
// Scoreboard bench for lsq_store_joiner (FIFO_DEPTH=4, MAX_OUTSTANDING=2); expected write pairs
// are queued as stimulus is issued and popped by a monitor whenever a write handshake occurs.
module tb_lsq_store_joiner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataIn;
  logic        dataIn_valid;
  logic        dataIn_ready;
  logic [31:0] addrIn;
  logic        addrIn_valid;
  logic        addrIn_ready;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memWrite_valid;
  logic        memWrite_ready;
  logic        memAck;
  logic [7:0]  pending;
  logic        idle;
  logic        ackErr;
`ifdef LSQ_STORE_JOINER_PERF_EN
  logic [31:0] stallCycles;
`endif

  int tests = 0;
  int fails = 0;

  logic [63:0] expQ[$];
  logic [31:0] dataQ[$];
  logic [31:0] addrQ[$];

  lsq_store_joiner #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .dataIn(dataIn), .dataIn_valid(dataIn_valid), .dataIn_ready(dataIn_ready),
    .addrIn(addrIn), .addrIn_valid(addrIn_valid), .addrIn_ready(addrIn_ready),
    .memAddr(memAddr), .memData(memData),
    .memWrite_valid(memWrite_valid), .memWrite_ready(memWrite_ready),
    .memAck(memAck), .pending(pending), .idle(idle), .ackErr(ackErr)
`ifdef LSQ_STORE_JOINER_PERF_EN
    , .stallCycles(stallCycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives queued data/addresses each cycle; optionally acks whenever a write is in flight.
  task automatic applyStimulus(input int cycles, input bit autoAck);
    bit dAcc, aAcc;
    for (int i = 0; i < cycles; i++) begin
      dataIn_valid = (dataQ.size() != 0);
      if (dataIn_valid) dataIn = dataQ[0];
      addrIn_valid = (addrQ.size() != 0);
      if (addrIn_valid) addrIn = addrQ[0];
      memAck = autoAck && (pending != 8'd0);
      dAcc = dataIn_valid && dataIn_ready;
      aAcc = addrIn_valid && addrIn_ready;
      tick();
      if (dAcc) void'(dataQ.pop_front());
      if (aAcc) void'(addrQ.pop_front());
    end
    dataIn_valid = 1'b0;
    addrIn_valid = 1'b0;
    memAck       = 1'b0;
  endtask

  task automatic queuePair(input logic [31:0] a, input logic [31:0] d);
    addrQ.push_back(a);
    dataQ.push_back(d);
    expQ.push_back({a, d});
  endtask

  always @(negedge clk) begin
    if (rst && memWrite_valid && memWrite_ready) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got 0x%0h/0x%0h, expected no write", memAddr, memData);
      end else begin
        checkOutput("write_pair", {memAddr, memData}, expQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    dataIn = '0; dataIn_valid = 1'b0;
    addrIn = '0; addrIn_valid = 1'b0;
    memWrite_ready = 1'b0; memAck = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset values
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_dready", 64'(dataIn_ready), 64'd1);
    checkOutput("rst_aready", 64'(addrIn_ready), 64'd1);
    checkOutput("rst_valid", 64'(memWrite_valid), 64'd0);
    checkOutput("rst_addr_data", {memAddr, memData}, 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_ackerr", 64'(ackErr), 64'd0);

    // Single write, channels arriving three cycles apart
    memWrite_ready = 1'b1;
    dataIn = 32'hDEADBEEF; dataIn_valid = 1'b1;
    tick();
    dataIn_valid = 1'b0;
    tick(); tick();
    addrIn = 32'h40; addrIn_valid = 1'b1;
    expQ.push_back({32'h40, 32'hDEADBEEF});
    tick();
    addrIn_valid = 1'b0;
    checkOutput("lat_n1_valid", 64'(memWrite_valid), 64'd0);
    tick();
    checkOutput("lat_n2_valid", 64'(memWrite_valid), 64'd1);
    checkOutput("lat_n2_pair", {memAddr, memData}, {32'h40, 32'hDEADBEEF});
    tick();
    checkOutput("single_pending", 64'(pending), 64'd1);
    checkOutput("single_not_idle", 64'(idle), 64'd0);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("single_pending_ack", 64'(pending), 64'd0);
    checkOutput("single_idle", 64'(idle), 64'd1);

    // Back-pressure: request held stable for three cycles
    memWrite_ready = 1'b0;
    queuePair(32'h1234, 32'hCAFEF00D);
    applyStimulus(2, 1'b0);
    checkOutput("stall_valid", 64'(memWrite_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_hold", {32'(memWrite_valid), 32'(pending)}, {32'd1, 32'd0});
      checkOutput("stall_stable", {memAddr, memData}, {32'h1234, 32'hCAFEF00D});
    end
`ifdef LSQ_STORE_JOINER_PERF_EN
    checkOutput("stall_count", 64'(stallCycles), 64'd3);
`endif
    memWrite_ready = 1'b1;
    tick();
    checkOutput("stall_done_valid", 64'(memWrite_valid), 64'd0);
    checkOutput("stall_done_pending", 64'(pending), 64'd1);
`ifdef LSQ_STORE_JOINER_PERF_EN
    checkOutput("stall_count_after", 64'(stallCycles), 64'd3);
`endif
    applyStimulus(4, 1'b1);
    checkOutput("stall_drain_idle", 64'(idle), 64'd1);

    // Data FIFO fills with no addresses; fifth word must wait
    for (int i = 0; i < 5; i++) begin
      dataQ.push_back(32'hD000_0000 + 32'(i));
      expQ.push_back({32'hA000_0000 + 32'(i), 32'hD000_0000 + 32'(i)});
    end
    applyStimulus(6, 1'b0);
    checkOutput("full_dready", 64'(dataIn_ready), 64'd0);
    checkOutput("full_aready", 64'(addrIn_ready), 64'd1);
    checkOutput("full_no_write", 64'(memWrite_valid), 64'd0);
    for (int i = 0; i < 4; i++) addrQ.push_back(32'hA000_0000 + 32'(i));
    applyStimulus(16, 1'b1);
    checkOutput("fifth_waits_q", 64'(expQ.size()), 64'd1);
    checkOutput("fifth_waits_valid", 64'(memWrite_valid), 64'd0);
    checkOutput("fifth_dready", 64'(dataIn_ready), 64'd1);
    checkOutput("fifth_not_idle", 64'(idle), 64'd0);
    addrQ.push_back(32'hA000_0004);
    applyStimulus(8, 1'b1);
    checkOutput("fifth_done_q", 64'(expQ.size()), 64'd0);
    checkOutput("fifth_done_idle", 64'(idle), 64'd1);

    // Throttle at two outstanding writes, released by one ack
    for (int i = 0; i < 4; i++) queuePair(32'hB000_0000 + 32'(i), 32'hE000_0000 + 32'(i));
    applyStimulus(10, 1'b0);
    checkOutput("thr_pending", 64'(pending), 64'd2);
    checkOutput("thr_valid", 64'(memWrite_valid), 64'd0);
    checkOutput("thr_issued", 64'(expQ.size()), 64'd2);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("thr_ack_load", 64'(memWrite_valid), 64'd1);
    checkOutput("thr_ack_pending", 64'(pending), 64'd1);
    checkOutput("thr_ack_pair", {memAddr, memData}, {32'hB000_0002, 32'hE000_0002});
    applyStimulus(10, 1'b1);
    checkOutput("thr_drain_q", 64'(expQ.size()), 64'd0);
    checkOutput("thr_drain_idle", 64'(idle), 64'd1);

    // Spurious ack is sticky
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    checkOutput("ackerr_set", 64'(ackErr), 64'd1);
    checkOutput("ackerr_pending", 64'(pending), 64'd0);
    repeat (3) tick();
    checkOutput("ackerr_sticky", 64'(ackErr), 64'd1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) queuePair(32'hC000_0000 + 32'(i), 32'hF000_0000 + 32'(i));
    applyStimulus(4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(memWrite_valid), 64'd0);
    checkOutput("arst_addr_data", {memAddr, memData}, 64'd0);
    checkOutput("arst_pending", 64'(pending), 64'd0);
    checkOutput("arst_flags", {32'(idle), 32'(ackErr)}, {32'd1, 32'd0});
    checkOutput("arst_ready", {32'(dataIn_ready), 32'(addrIn_ready)}, {32'd1, 32'd1});
    expQ.delete();
    dataQ.delete();
    addrQ.delete();
    tick();
    rst = 1'b1;
    queuePair(32'h0000_0088, 32'h1357_9BDF);
    applyStimulus(8, 1'b1);
    checkOutput("post_rst_q", 64'(expQ.size()), 64'd0);
    checkOutput("post_rst_idle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
